// File: rtl/wb_flash_prog_seq_pkg.sv
`default_nettype none
// Shared constants for the NOR flash command sequencer: flash opcodes, register map,
// STATUS bit positions, software op codes and FSM state encoding.
package wb_flash_prog_seq_pkg;

  localparam logic [15:0] FL_PROGRAM    = 16'h0040;
  localparam logic [15:0] FL_ERASE      = 16'h0020;
  localparam logic [15:0] FL_CONFIRM    = 16'h00D0;
  localparam logic [15:0] FL_RD_STATUS  = 16'h0070;
  localparam logic [15:0] FL_CLR_STATUS = 16'h0050;
  localparam logic [15:0] FL_RD_ARRAY   = 16'h00FF;

  localparam logic [1:0] REG_ADDR   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CMD    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_TIMEOUT = 3;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_PROGRAM = 2'd1;
  localparam logic [1:0] OP_ERASE   = 2'd2;
  localparam logic [1:0] OP_RDSTAT  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CMD1 = 4'd1,
    S_CMD2 = 4'd2,
    S_RSC  = 4'd3,
    S_POLL = 4'd4,
    S_CHK  = 4'd5,
    S_CLR  = 4'd6,
    S_RA   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  // The flash sits on the bus byte-swapped relative to the CPU view.
  function automatic logic [15:0] swap16(input logic [15:0] h);
    return {h[7:0], h[15:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_flash_seq_master.sv
`default_nettype none
// Single-access Wishbone master: holds one request stable until ack, then pulses done.
// The done cycle doubles as the mandatory idle gap before the next access.
module wb_flash_seq_master
  import wb_flash_prog_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [15:0] hw,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [31:0] m_adr,
  output logic [3:0]  m_sel,
  output logic [31:0] m_dat,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack,
  output logic        done,
  output logic [7:0]  sr
);

  logic unused_bits;
  assign unused_bits = ^{adr[1:0], m_dat_i[23:16], m_dat_i[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 1'b0;
      m_stb <= 1'b0;
      m_we  <= 1'b0;
      m_adr <= '0;
      m_sel <= '0;
      m_dat <= '0;
      done  <= 1'b0;
      sr    <= '0;
    end else begin
      done <= 1'b0;
      if (m_cyc) begin
        if (m_ack) begin
          m_cyc <= 1'b0;
          m_stb <= 1'b0;
          m_we  <= 1'b0;
          done  <= 1'b1;
          // Upper half-word lane when ADDR[1]=0 (sel 1100), lower lane otherwise.
          if (!m_we) sr <= m_sel[0] ? m_dat_i[15:8] : m_dat_i[31:24];
        end
      end else if (req && !done) begin
        m_cyc <= 1'b1;
        m_stb <= 1'b1;
        m_we  <= we;
        m_adr <= {adr[31:2], 2'b00};
        m_sel <= sel;
        m_dat <= {swap16(hw), swap16(hw)};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_flash_prog_seq.sv
`default_nettype none
// NOR flash command sequencer: four-register Wishbone slave plus an FSM that drives
// program / erase / read-status sequences through a single-access Wishbone master.
module wb_flash_prog_seq
  import wb_flash_prog_seq_pkg::*;
#(
  parameter logic [23:0] POLL_LIMIT = 24'd1_000_000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [1:0]  s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  output logic        irq_o
);

  state_t      state, state_nx;
  logic [31:0] addr;
  logic [15:0] data;
  logic [1:0]  op;
  logic        busy, done, err, timeout;
  logic [23:0] poll_cnt;
  logic        acc_req, acc_we, acc_done;
  logic [15:0] acc_hw;
  logic [7:0]  sr;
  logic        s_req, s_wr, cmd_start;
  logic [31:0] rd_data;
  logic [7:0]  status_lo;

  assign s_req     = s_cyc_i & s_stb_i & ~s_ack_o;
  assign s_wr      = s_req & s_we_i;
  assign cmd_start = s_wr && (s_adr_i == REG_CMD) && (s_dat_i[1:0] != OP_NOP) && !busy;
  assign irq_o     = done;

  always_comb begin
    status_lo              = '0;
    status_lo[ST_BUSY]     = busy;
    status_lo[ST_DONE]     = done;
    status_lo[ST_ERR]      = err;
    status_lo[ST_TIMEOUT]  = timeout;
    case (s_adr_i)
      REG_ADDR:   rd_data = addr;
      REG_DATA:   rd_data = {16'h0000, data};
      REG_STATUS: rd_data = {16'h0000, sr, status_lo};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    acc_req  = 1'b0;
    acc_we   = 1'b1;
    acc_hw   = '0;
    case (state)
      S_IDLE: if (cmd_start) state_nx = (s_dat_i[1:0] == OP_RDSTAT) ? S_RSC : S_CMD1;
      S_CMD1: begin
        acc_req = 1'b1;
        acc_hw  = (op == OP_PROGRAM) ? FL_PROGRAM : FL_ERASE;
        if (acc_done) state_nx = S_CMD2;
      end
      S_CMD2: begin
        acc_req = 1'b1;
        acc_hw  = (op == OP_PROGRAM) ? data : FL_CONFIRM;
        if (acc_done) state_nx = S_RSC;
      end
      S_RSC: begin
        acc_req = 1'b1;
        acc_hw  = FL_RD_STATUS;
        if (acc_done) state_nx = S_POLL;
      end
      S_POLL: begin
        acc_req = 1'b1;
        acc_we  = 1'b0;
        if (acc_done) state_nx = (op == OP_RDSTAT) ? S_RA : S_CHK;
      end
      S_CHK: begin
        if (sr[7])                      state_nx = (|sr[5:1]) ? S_CLR : S_RA;
        else if (poll_cnt >= POLL_LIMIT) state_nx = S_RA;
        else                            state_nx = S_POLL;
      end
      S_CLR: begin
        acc_req = 1'b1;
        acc_hw  = FL_CLR_STATUS;
        if (acc_done) state_nx = S_RA;
      end
      S_RA: begin
        acc_req = 1'b1;
        acc_hw  = FL_RD_ARRAY;
        if (acc_done) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      addr     <= '0;
      data     <= '0;
      op       <= OP_NOP;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      poll_cnt <= '0;
      s_ack_o  <= 1'b0;
      s_dat_o  <= '0;
    end else begin
      s_ack_o <= s_req;
      if (s_req) s_dat_o <= rd_data;
      if (s_wr) begin
        case (s_adr_i)
          REG_ADDR:   if (!busy) addr <= s_dat_i;
          REG_DATA:   if (!busy) data <= s_dat_i[15:0];
          REG_STATUS: if (s_dat_i[ST_DONE]) done <= 1'b0;
          default:    ;
        endcase
      end
      if (cmd_start) begin
        op       <= s_dat_i[1:0];
        busy     <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        timeout  <= 1'b0;
        poll_cnt <= '0;
      end
      if (state == S_POLL && acc_done) poll_cnt <= poll_cnt + 24'd1;
      if (state == S_CHK) begin
        if (sr[7])                       err     <= |sr[5:1];
        else if (poll_cnt >= POLL_LIMIT) timeout <= 1'b1;
      end
      // Placed last so that a same-edge software clear still leaves done set.
      if (state == S_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

  wb_flash_seq_master u_master (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (acc_req),
    .we      (acc_we),
    .adr     (addr),
    .sel     (addr[1] ? 4'b0011 : 4'b1100),
    .hw      (acc_hw),
    .m_cyc   (m_cyc_o),
    .m_stb   (m_stb_o),
    .m_we    (m_we_o),
    .m_adr   (m_adr_o),
    .m_sel   (m_sel_o),
    .m_dat   (m_dat_o),
    .m_dat_i (m_dat_i),
    .m_ack   (m_ack_i),
    .done    (acc_done),
    .sr      (sr)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_flash_prog_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for wb_flash_prog_seq: flash responder, expected-access model and directed tests.
module tb_wb_flash_prog_seq;

  localparam logic [23:0] LIMIT = 24'd4;
  localparam logic [1:0] A_ADDR = 2'd0, A_DATA = 2'd1, A_CMD = 2'd2, A_STATUS = 2'd3;

  logic        clk = 1'b0, rst = 1'b0;
  logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [1:0]  s_adr = '0;
  logic [31:0] s_dat_w = '0, s_dat_r;
  logic        s_ack;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_o;
  logic [3:0]  m_sel;
  logic [31:0] m_dat_i = '0;
  logic        m_ack = 1'b0;
  logic        irq;

  wb_flash_prog_seq #(.POLL_LIMIT(LIMIT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_adr_i(s_adr),
    .s_dat_i(s_dat_w), .s_dat_o(s_dat_r), .s_ack_o(s_ack),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_adr_o(m_adr),
    .m_sel_o(m_sel), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] wr_log[$];
  int          ready_after = 1, read_count = 0, waits = 2;
  logic [7:0]  sr_final = '0;

  function automatic logic [31:0] bus_word(input logic [15:0] h);
    logic [7:0] lo, hi;
    lo = h[7:0];
    hi = h[15:8];
    return {lo, hi, lo, hi};
  endfunction

  function automatic acc_t mk(input logic we, input logic [31:0] a, input logic [15:0] h);
    acc_t e;
    e.we  = we;
    e.adr = {a[31:2], 2'b00};
    e.sel = a[1] ? 4'b0011 : 4'b1100;
    e.dat = we ? bus_word(h) : 32'h0;
    return e;
  endfunction

  // Expected access list and final STATUS, from the command-sequence rules.
  task automatic expect_run(input logic [1:0] op, input logic [31:0] a, input logic [15:0] d,
                            output logic [31:0] status);
    int polls;
    logic [7:0] last;
    logic ready, e, t;
    exp_q.delete();
    e = 1'b0;
    t = 1'b0;
    if (op == 2'd3) begin
      exp_q.push_back(mk(1'b1, a, 16'h0070));
      exp_q.push_back(mk(1'b0, a, 16'h0000));
      last = (ready_after <= 1) ? sr_final : 8'h00;
    end else begin
      exp_q.push_back(mk(1'b1, a, (op == 2'd1) ? 16'h0040 : 16'h0020));
      exp_q.push_back(mk(1'b1, a, (op == 2'd1) ? d : 16'h00D0));
      exp_q.push_back(mk(1'b1, a, 16'h0070));
      ready = (ready_after <= int'(LIMIT));
      polls = ready ? ready_after : int'(LIMIT);
      for (int i = 0; i < polls; i++) exp_q.push_back(mk(1'b0, a, 16'h0000));
      last = ready ? sr_final : 8'h00;
      e = ready && (|sr_final[5:1]);
      t = !ready;
      if (e) exp_q.push_back(mk(1'b1, a, 16'h0050));
    end
    exp_q.push_back(mk(1'b1, a, 16'h00FF));
    status = {16'h0000, last, 4'h0, t, e, 1'b1, 1'b0};
  endtask

  // Flash-side responder and per-cycle master checker.
  int          wcnt = 0;
  logic        have_snap = 1'b0;
  logic [31:0] snap_adr;
  logic [36:0] snap_ctl;
  acc_t        rsp_e;
  logic [7:0]  rsp_sr;

  always @(negedge clk) begin
    if (rst) begin
      m_ack = 1'b0;
      wcnt = 0;
      have_snap = 1'b0;
    end else if (m_ack) begin
      m_ack = 1'b0;
      have_snap = 1'b0;
      chk("m_stb_drop_after_ack", {m_cyc, m_stb}, 2'b00);
    end else if (m_cyc && m_stb) begin
      if (have_snap) begin
        chk("m_hold_adr", m_adr, snap_adr);
        chk("m_hold_ctl", {m_we, m_sel, m_dat_o}, snap_ctl);
      end else begin
        have_snap = 1'b1;
        snap_adr = m_adr;
        snap_ctl = {m_we, m_sel, m_dat_o};
      end
      if (wcnt < waits) wcnt++;
      else begin
        wcnt = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_access: got we=%0b adr=%0h dat=%0h expected none", m_we, m_adr, m_dat_o);
        end else begin
          rsp_e = exp_q.pop_front();
          chk("acc_we", m_we, rsp_e.we);
          chk("acc_adr", m_adr, rsp_e.adr);
          chk("acc_sel", m_sel, rsp_e.sel);
          if (rsp_e.we) chk("acc_dat", m_dat_o, rsp_e.dat);
        end
        if (m_we) wr_log.push_back(m_dat_o);
        else begin
          read_count++;
          rsp_sr = (read_count >= ready_after) ? sr_final : 8'h00;
          // Decoy byte in the other lane has SR[7]=0 and error bits set.
          m_dat_i = (m_sel == 4'b0011) ? {8'h3E, 8'h00, rsp_sr, 8'h00}
                                       : {rsp_sr, 8'h00, 8'h3E, 8'h00};
        end
        m_ack = 1'b1;
      end
    end
  end

  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d, output logic [31:0] q);
    int n;
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = a; s_dat_w = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ack && n < 8);
    chk("s_ack_latency", n, 1);
    q = s_dat_r;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic reg_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus(1'b0, a, 32'h0, q);
    chk(name, q, exp);
    @(negedge clk);
    chk("s_ack_one_cycle", s_ack, 1'b0);
  endtask

  task automatic setup(input logic [1:0] op, input logic [31:0] a, input logic [15:0] d,
                       input int rdy, input logic [7:0] srf, output logic [31:0] st);
    ready_after = rdy;
    sr_final = srf;
    read_count = 0;
    wr_log.delete();
    expect_run(op, a, d, st);
    reg_wr(A_ADDR, a);
    reg_wr(A_DATA, {16'h0000, d});
  endtask

  task automatic start_cmd(input logic [1:0] op);
    reg_wr(A_CMD, {30'h0, op});
    chk("stb_low_in_ack_cycle", m_stb, 1'b0);
    @(negedge clk);
    chk("start_stb", m_stb, 1'b1);
    chk("s_ack_one_cycle", s_ack, 1'b0);
  endtask

  task automatic finish(input string name, input logic [31:0] st);
    int n;
    n = 0;
    while (!irq && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("irq_wait_expired", 0, 1);
    repeat (2) @(negedge clk);
    chk("irq_level", irq, 1'b1);
    chk("accesses_left", exp_q.size(), 0);
    reg_rd(name, A_STATUS, st);
  endtask

  logic [31:0] st;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m_cyc, m_stb, m_we, m_sel, s_ack, irq}, '0);
    chk("reset_m_adr", m_adr, '0);
    chk("reset_m_dat", m_dat_o, '0);
    chk("reset_s_dat", s_dat_r, '0);
    rst = 1'b0;
    reg_rd("reset_status", A_STATUS, 32'h0);

    // Program: SR ready on the 3rd poll.
    setup(2'd1, 32'h100, 16'hA55A, 3, 8'h80, st);
    chk("model_prog_status", st, 32'h8002);
    start_cmd(2'd1);
    finish("prog_status", 32'h8002);
    chk("prog_reads", read_count, 3);
    chk("prog_wr_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("prog_w0", wr_log[0], 32'h40004000);
      chk("prog_w1", wr_log[1], 32'h5AA55AA5);
      chk("prog_w2", wr_log[2], 32'h70007000);
      chk("prog_w3", wr_log[3], 32'hFF00FF00);
    end
    reg_wr(A_STATUS, 32'h2);
    reg_rd("done_cleared", A_STATUS, 32'h8000);
    chk("irq_cleared", irq, 1'b0);

    // Erase with error on odd half-word address.
    setup(2'd2, 32'h20002, 16'h0000, 1, 8'hA0, st);
    chk("model_err_status", st, 32'hA006);
    start_cmd(2'd2);
    finish("erase_err_status", 32'hA006);
    chk("erase_wr_count", wr_log.size(), 5);
    if (wr_log.size() == 5) begin
      chk("erase_clr", wr_log[3], 32'h50005000);
      chk("erase_ra", wr_log[4], 32'hFF00FF00);
    end

    // Timeout: SR never ready.
    setup(2'd2, 32'h40, 16'h0000, 1000, 8'h80, st);
    chk("model_to_status", st, 32'h000A);
    start_cmd(2'd2);
    finish("timeout_status", 32'h000A);
    chk("timeout_reads", read_count, 4);

    // Busy protection.
    setup(2'd2, 32'h300, 16'h0BAD, 2, 8'h80, st);
    start_cmd(2'd2);
    repeat (3) @(negedge clk);
    reg_wr(A_ADDR, 32'h999);
    reg_wr(A_CMD, 32'h2);
    reg_wr(A_DATA, 32'h1234);
    begin
      logic [31:0] q;
      bus(1'b0, A_STATUS, 32'h0, q);
      chk("busy_bits", q[3:0], 4'b0001);
    end
    finish("busy_status", 32'h8002);
    reg_rd("busy_addr_kept", A_ADDR, 32'h300);
    reg_rd("busy_data_kept", A_DATA, 32'h0BAD);

    // Read-status: single read, no poll loop.
    setup(2'd3, 32'h100, 16'h0000, 1, 8'h80, st);
    chk("model_rs_status", st, 32'h8002);
    start_cmd(2'd3);
    finish("rdstat_status", 32'h8002);
    chk("rdstat_reads", read_count, 1);

    // Async reset while an access is outstanding.
    waits = 50;
    setup(2'd1, 32'h500, 16'h1111, 1, 8'h80, st);
    start_cmd(2'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_cyc_drop", m_cyc, 1'b0);
    chk("rst_stb_drop", m_stb, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waits = 2;
    reg_rd("rst_addr", A_ADDR, 32'h0);
    reg_rd("rst_data", A_DATA, 32'h0);
    reg_rd("rst_cmd", A_CMD, 32'h0);
    reg_rd("rst_status", A_STATUS, 32'h0);
    repeat (30) @(negedge clk);
    chk("no_access_after_reset", m_cyc, 1'b0);
    chk("rst_irq", irq, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/wb_flash_prog_seq.md
# wb_flash_prog_seq

Command sequencer for the Intel-style parallel NOR flash behind `wb_flash_if`. Software programs address, data and an opcode through a four-register Wishbone slave port. The block then acts as Wishbone master toward `wb_flash_if` and issues the multi-cycle flash command sequence:
- word program, block erase, or status read;
- status-register polling;
- error clear and return to read-array mode.

It sits between the system bus and the flash-interface slave port, in front of the bus mux that also carries plain array reads.

## Interface
- `POLL_LIMIT`, 24'd1_000_000: maximum status reads before a timeout is declared.
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `s_cyc_i`, `s_stb_i`, `s_we_i` in 1: register-slave strobes.
- `s_adr_i` in 2: register select, byte offset [3:2].
- `s_dat_i` in 32: register write data.
- `s_dat_o` out 32: register read data.
- `s_ack_o` out 1: register ack.
- `m_cyc_o`, `m_stb_o`, `m_we_o` out 1: master strobes toward `wb_flash_if`.
- `m_adr_o` out 32: master byte address, {ADDR[31:2], 2'b00}.
- `m_sel_o` out 4: 4'b1100 when ADDR[1]=0, 4'b0011 when ADDR[1]=1.
- `m_dat_o` out 32: {sw(h), sw(h)}, where sw(h) = {h[7:0], h[15:8]} and h is the 16-bit flash word.
- `m_dat_i` in 32: master read data.
- `m_ack_i` in 1: master ack.
- `irq_o` out 1: level; equals STATUS.done.

## Operation
- **Registers**
  - 0x0 ADDR: rw, 32 bits.
  - 0x4 DATA: rw, [15:0].
  - 0x8 CMD: wo; [1:0] op: 1 = program, 2 = erase, 3 = read-status, 0 = no-op. Writing a nonzero op starts a sequence. Reads return 0.
  - 0xC STATUS: ro except bit 1.
    - [0] busy; [1] done, write 1 to clear; [2] err; [3] timeout.
    - [15:8] last status-register byte SR.
- **Register rules**
  - Writes to ADDR, DATA or CMD while busy are ignored; they are still acked.
  - Starting a new op clears done, err, timeout.
- **Sequences** (each step is one master access; W = write half-word h, R = read):
  - program: W 0x0040, W DATA, W 0x0070, poll.
  - erase: W 0x0020, W 0x00D0, W 0x0070, poll.
  - read-status: W 0x0070, R once.
  - All sequences end with W 0x00FF, then DONE.
- **Poll**: repeat R until SR[7]=1.
  - SR = ADDR[1] ? m_dat_i[15:8] : m_dat_i[31:24].
  - err = |SR[5:1]. If err, W 0x0050 before W 0x00FF.
  - The poll counter is 24-bit. If POLL_LIMIT reads complete with SR[7]=0: set timeout, skip the clear, go to W 0x00FF.
- **FSM states**: IDLE, CMD1, CMD2, RSC, POLL, CHK, CLR, RA, DONE.
  - IDLE: on a CMD write, go to CMD1 for op 1/2, or RSC for op 3.
  - CMD1 → CMD2 → RSC.
  - RSC: go to POLL.
  - POLL: go to CHK. For op 3, go to RA after the single read.
  - CHK: go to POLL, CLR, or RA.
  - CLR → RA → DONE → IDLE.
  - DONE: set done, clear busy.
- **Master access rule**
  - cyc/stb/we/adr/sel/dat are registered and held stable until the cycle `m_ack_i`=1.
  - stb and cyc deassert on the next edge and stay low for at least one cycle before the next access.
  - `m_err_i` / `m_rty_i` do not exist; the slave never raises them.

## Timing
- **Reset values**: all outputs 0; registers 0; state IDLE.
- **Slave port**
  - `s_ack_o` rises one cycle after s_cyc&s_stb and stays high exactly one cycle. There are no wait states.
  - A register write takes effect on the ack edge.
  - s_dat_o is valid with ack.
- **Start latency**: `m_stb_o` rises the cycle after the CMD write ack.
- **Access spacing**: minimum 1 idle cycle between accesses.
- **Per-access latency**: set entirely by `wb_flash_if` wait states.
- busy rises with the CMD ack and falls in the same edge that sets done.
- **Async reset mid-access**: `m_cyc_o` drops immediately, the sequence is abandoned, and no read-array write is issued.
- done and `irq_o` stay set until cleared by software or reset. A clear write and a simultaneous DONE entry resolve to done=1.

## Structure
- **Shared defines file**:
  - flash opcodes 0x40/0x20/0xD0/0x70/0x50/0xFF;
  - register offsets;
  - STATUS bit positions;
  - op codes;
  - FSM state encodings (4-bit).
- **Sub-module `wb_flash_seq_master`**: single-access Wishbone master engine.
  - Inputs: req, we, adr, sel, half-word.
  - Outputs: done pulse, SR byte.
  - Enforces hold-until-ack and the idle-gap rule.
- Top level holds the register file, FSM and poll counter.

## Test plan
- **Program**: ADDR=0x100, DATA=0xA55A, CMD=1, flash model returns SR=0x80 on the 3rd poll.
  - Master writes 0x0040, 0xA55A, 0x0070 at 0x100 with sel 1100, byte-swapped.
  - 3 reads, then W 0x00FF.
  - STATUS=0x8002; `irq_o`=1.
- **Erase with error**: ADDR=0x20002, CMD=2, SR=0xA0.
  - Sequence uses sel 0011.
  - W 0x0050 issued before 0x00FF.
  - STATUS = 0xA006.
- **Timeout**: POLL_LIMIT=4, SR stuck at 0x00.
  - Exactly 4 reads, no 0x50, 0xFF issued.
  - STATUS = 0x000A.
- **Busy protection**: CMD=2 written while busy.
  - Acked, ignored; ADDR unchanged; only one sequence runs.
- **Read-status**: CMD=3, SR=0x80.
  - W 0x70, 1 R, W 0xFF.
  - STATUS[15:8]=0x80; no poll loop.
- **Async reset mid-access**: `wb_rst_i` asserted while `m_stb_o`=1 and no ack yet.
  - `m_cyc_o`=0 immediately.
  - All registers read back 0 after release.
